// File: rtl/sum_pkg.sv
// Shared widths and handshake state encoding for the sum stage and its accumulator.
package sum_pkg;

    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned SUM_W     = OPERAND_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage : sum_pkg

// File: rtl/sum_accumulator.sv
// Accumulates COUNT incoming sums (or fewer on flush) into one widened total,
// presented on a valid/ready output held stable until downstream accepts it.
module sum_accumulator
    import sum_pkg::*;
#(
    parameter  int unsigned IN_W  = SUM_W,
    parameter  int unsigned COUNT = 4,
    localparam int unsigned OUT_W = IN_W + $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic [8:0]       out_beats,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = 9;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;
    logic               out_valid_q, out_valid_d;

    logic               beat;
    logic [OUT_W-1:0]   sum;
    logic               last_beat;

    assign in_ready  = (state_q == ACCUM) & ~rst;
    assign beat      = in_valid & in_ready;
    assign sum       = acc_q + OUT_W'(in_data);
    assign last_beat = (cnt_q == CNT_W'(COUNT - 1));

    // Next-state: accumulate, emit on full count or flush, hold until accepted.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ACCUM: begin
                if (beat && (last_beat || flush)) begin
                    out_data_d  = sum;
                    out_beats_d = cnt_q + CNT_W'(1);
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = HOLD;
                end else if (beat) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (flush && (cnt_q != '0)) begin
                    out_data_d  = acc_q;
                    out_beats_d = cnt_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_valid = out_valid_q;

endmodule : sum_accumulator
